// File: rtl/pwm_pkg.sv
// Shared types and limits for the multi-channel PWM compare block.
// The dead-band FSM is only used when PWM_DEADTIME_EN is defined.
package pwm_pkg;

    // Largest supported number of compare channels
    localparam int unsigned NUM_CH_MAX = 16;

    // Dead-band FSM states
    typedef enum logic [1:0] {
        DB_OFF = 2'd0,  // both outputs low
        DB_HI  = 2'd1,  // high side on
        DB_LO  = 2'd2,  // low side on
        DB_DT  = 2'd3   // both low while the dead-band counter runs
    } db_state_e;

endpackage

// File: rtl/pwm_deadband.sv
// Per-channel dead-band inserter: turns the raw compare bit into a
// complementary pair that is never high together and is separated by
// deadtime_cycles low-low cycles at every transition.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                raw,
    input  logic [DT_WIDTH-1:0] deadtime_cycles,
    output logic                pwm_out,
    output logic                pwm_out_n
);

    db_state_e           state_q, state_d;
    logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
    logic                raw_q;
    db_state_e           target;
    logic                raw_chg;

    assign target  = raw ? DB_HI : DB_LO;
    assign raw_chg = (raw != raw_q);

    // State, counter, raw history and registered output decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DB_OFF;
            dt_cnt_q  <= '0;
            raw_q     <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_out_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            dt_cnt_q  <= dt_cnt_d;
            raw_q     <= raw;
            pwm_out   <= (state_d == DB_HI);
            pwm_out_n <= (state_d == DB_LO);
        end
    end

    // Next-state and dead-band counter logic
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!enable) begin
            state_d  = DB_OFF;
            dt_cnt_d = '0;
        end else begin
            case (state_q)
                DB_OFF: begin
                    state_d = target;
                end
                DB_HI, DB_LO: begin
                    if (state_q != target) begin
                        if (deadtime_cycles == '0) begin
                            state_d = target;
                        end else begin
                            state_d  = DB_DT;
                            dt_cnt_d = deadtime_cycles;
                        end
                    end
                end
                DB_DT: begin
                    if (raw_chg) begin
                        if (deadtime_cycles == '0) begin
                            state_d  = target;
                            dt_cnt_d = '0;
                        end else begin
                            dt_cnt_d = deadtime_cycles;
                        end
                    end else if (dt_cnt_q <= DT_WIDTH'(1)) begin
                        state_d  = target;
                        dt_cnt_d = '0;
                    end else begin
                        dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d  = DB_OFF;
                    dt_cnt_d = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_compare_mc.sv
// Multi-channel PWM compare stage fed by an external timebase.
// Each channel has a shadow/active duty pair committed at period_end.
// Optional dead-band insertion is enabled with the PWM_DEADTIME_EN macro.
module pwm_compare_mc
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [CNT_WIDTH-1:0]          cnt,
    input  logic [CNT_WIDTH-1:0]          period_cycles_eff,
    input  logic                          period_end,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   duty_cycles,
    input  logic [NUM_CH-1:0]             duty_wr,
    input  logic [DT_WIDTH-1:0]           deadtime_cycles,
    output logic [NUM_CH-1:0]             pwm_out,
    output logic [NUM_CH-1:0]             pwm_out_n,
    output logic [NUM_CH-1:0]             upd_done
);

    logic [NUM_CH-1:0] raw;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_WIDTH-1:0] duty_in;
        logic [CNT_WIDTH-1:0] shadow_q;
        logic [CNT_WIDTH-1:0] active_q;
        logic [CNT_WIDTH-1:0] duty_eff;
        logic                 pending_q;
        logic                 upd_q;

        assign duty_in = duty_cycles[i*CNT_WIDTH +: CNT_WIDTH];

        // Shadow capture, period-aligned commit and commit pulse
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_q  <= '0;
                active_q  <= '0;
                pending_q <= 1'b0;
                upd_q     <= 1'b0;
            end else begin
                upd_q <= 1'b0;
                if (period_end && pending_q) begin
                    active_q  <= shadow_q;
                    pending_q <= 1'b0;
                    upd_q     <= 1'b1;
                end
                // A write in the commit cycle lands in the shadow for next period
                if (duty_wr[i]) begin
                    shadow_q  <= duty_in;
                    pending_q <= 1'b1;
                end
            end
        end

        // Saturate duty to the period, then compare against the timebase
        assign duty_eff = (active_q < period_cycles_eff) ? active_q : period_cycles_eff;
        assign raw[i]   = enable && (cnt < duty_eff);
        assign upd_done[i] = upd_q;

`ifdef PWM_DEADTIME_EN
        pwm_deadband #(
            .DT_WIDTH (DT_WIDTH)
        ) u_deadband (
            .clk             (clk),
            .rst_n           (rst_n),
            .enable          (enable),
            .raw             (raw[i]),
            .deadtime_cycles (deadtime_cycles),
            .pwm_out         (pwm_out[i]),
            .pwm_out_n       (pwm_out_n[i])
        );
`else
        logic out_q;
        logic out_n_q;

        // Registered complementary pair; both low while disabled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q   <= 1'b0;
                out_n_q <= 1'b0;
            end else begin
                out_q   <= raw[i];
                out_n_q <= enable & ~raw[i];
            end
        end

        assign pwm_out[i]   = out_q;
        assign pwm_out_n[i] = out_n_q;
`endif
    end

`ifndef PWM_DEADTIME_EN
    // Dead-time input is accepted but has no effect in this build
    logic unused_deadtime;
    assign unused_deadtime = ^deadtime_cycles;
`endif

endmodule

// File: tb/tb_pwm_compare_mc.sv
// Directed self-checking bench for pwm_compare_mc (period 10, 4 channels).
// Build with PWM_DEADTIME_EN to exercise the dead-band variant instead.
module tb_pwm_compare_mc;

    localparam int unsigned CW = 32;
    localparam int unsigned NC = 4;
    localparam int unsigned DW = 8;
    localparam logic [31:0] PER = 32'd10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   period_cycles_eff;
    logic            period_end;
    logic [NC*CW-1:0] duty_cycles;
    logic [NC-1:0]   duty_wr;
    logic [DW-1:0]   deadtime_cycles;
    logic [NC-1:0]   pwm_out;
    logic [NC-1:0]   pwm_out_n;
    logic [NC-1:0]   upd_done;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    int upd_cnt [NC];
    int snap;
    logic [9:0] hi, lo;

    pwm_compare_mc #(
        .CNT_WIDTH (CW),
        .NUM_CH    (NC),
        .DT_WIDTH  (DW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .cnt               (cnt),
        .period_cycles_eff (period_cycles_eff),
        .period_end        (period_end),
        .duty_cycles       (duty_cycles),
        .duty_wr           (duty_wr),
        .deadtime_cycles   (deadtime_cycles),
        .pwm_out           (pwm_out),
        .pwm_out_n         (pwm_out_n),
        .upd_done          (upd_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: sample just after the edge, then step the timebase
    task automatic tick();
        @(posedge clk);
        #1;
        if ((pwm_out & pwm_out_n) != '0) overlap++;
        for (int c = 0; c < NC; c++) upd_cnt[c] += int'(upd_done[c]);
        cnt        = (cnt == PER - 32'd1) ? 32'd0 : cnt + 32'd1;
        period_end = (cnt == PER - 32'd1);
        duty_wr    = '0;
    endtask

    task automatic write(input int ch, input logic [31:0] val);
        duty_cycles[ch*CW +: CW] = val;
        duty_wr[ch] = 1'b1;
        tick();
    endtask

    task automatic wait_cnt(input logic [31:0] target);
        int n = 0;
        while (cnt != target && n < 50) begin
            tick();
            n++;
        end
        check("align", 64'(cnt), 64'(target));
    endtask

    // Record one full period of a channel, bit k = output for cnt==k
    task automatic collect(input int ch, output logic [9:0] h, output logic [9:0] l);
        for (int k = 0; k < 10; k++) begin
            tick();
            h[k] = pwm_out[ch];
            l[k] = pwm_out_n[ch];
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++) upd_cnt[c] = 0;
        rst_n             = 1'b0;
        enable            = 1'b0;
        cnt               = '0;
        period_cycles_eff = PER;
        period_end        = 1'b0;
        duty_cycles       = '0;
        duty_wr           = '0;
        deadtime_cycles   = 8'd2;

        repeat (3) tick();
        check("rst_out", 64'(pwm_out), 64'h0);
        check("rst_out_n", 64'(pwm_out_n), 64'h0);
        check("rst_upd", 64'(upd_done), 64'h0);
        rst_n  = 1'b1;
        enable = 1'b1;

`ifndef PWM_DEADTIME_EN
        // Idle: duty 0 means high side low, low side high
        wait_cnt(0);
        collect(0, hi, lo);
        check("idle_hi", 64'(hi), 64'h000);
        check("idle_lo", 64'(lo), 64'h3FF);

        // Duty 3 on ch0 committed at period_end
        snap = upd_cnt[0];
        write(0, 32'd3);
        wait_cnt(0);
        collect(0, hi, lo);
        check("d3_hi", 64'(hi), 64'h007);
        check("d3_lo", 64'(lo), 64'h3F8);
        check("d3_upd", 64'(upd_cnt[0] - snap), 64'd1);

        // Duty above period saturates high, then zero goes low
        write(1, 32'd25);
        wait_cnt(0);
        collect(1, hi, lo);
        check("d25_hi", 64'(hi), 64'h3FF);
        check("d25_lo", 64'(lo), 64'h000);
        write(1, 32'd0);
        wait_cnt(0);
        collect(1, hi, lo);
        check("d0_hi", 64'(hi), 64'h000);
        check("d0_lo", 64'(lo), 64'h3FF);

        // Write coinciding with period_end commits the older shadow first
        snap = upd_cnt[2];
        write(2, 32'd6);
        wait_cnt(9);
        write(2, 32'd8);
        collect(2, hi, lo);
        check("coin_old", 64'(hi), 64'h03F);
        collect(2, hi, lo);
        check("coin_new", 64'(hi), 64'h0FF);
        check("coin_upd", 64'(upd_cnt[2] - snap), 64'd2);

        // Boundaries: duty == period, period-1, full-width maximum
        write(3, 32'd10);
        wait_cnt(0);
        collect(3, hi, lo);
        check("deq_hi", 64'(hi), 64'h3FF);
        write(3, 32'd9);
        wait_cnt(0);
        collect(3, hi, lo);
        check("dm1_hi", 64'(hi), 64'h1FF);
        write(3, 32'hFFFF_FFFF);
        wait_cnt(0);
        collect(3, hi, lo);
        check("dmax_hi", 64'(hi), 64'h3FF);

        // Enable drop at cnt 1 with duty 5
        write(0, 32'd5);
        wait_cnt(0);
        tick();
        check("pre_dis", 64'(pwm_out[0]), 64'h1);
        enable = 1'b0;
        tick();
        check("dis_out", 64'(pwm_out), 64'h0);
        check("dis_out_n", 64'(pwm_out_n), 64'h0);
        tick();
        check("dis_hold", 64'({pwm_out, pwm_out_n}), 64'h0);
        enable = 1'b1;

        // Reset mid-period with a pending write
        wait_cnt(0);
        tick();
        tick();
        write(0, 32'd7);
        check("pre_rst", 64'(pwm_out[0]), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", 64'(pwm_out), 64'h0);
        check("mid_rst_out_n", 64'(pwm_out_n), 64'h0);
        tick();
        tick();
        rst_n = 1'b1;
        snap = upd_cnt[0];
        wait_cnt(0);
        collect(0, hi, lo);
        check("post_rst_hi", 64'(hi), 64'h000);
        check("post_rst_lo", 64'(lo), 64'h3FF);
        collect(0, hi, lo);
        check("post_rst_hi2", 64'(hi), 64'h000);
        check("post_rst_upd", 64'(upd_cnt[0] - snap), 64'd0);
        snap = upd_cnt[0];
        write(0, 32'd2);
        wait_cnt(0);
        collect(0, hi, lo);
        check("rewrite_hi", 64'(hi), 64'h003);
        check("rewrite_upd", 64'(upd_cnt[0] - snap), 64'd1);
`else
        // Dead time 2 with duty 4: two low-low cycles at each edge
        write(0, 32'd4);
        wait_cnt(0);
        collect(0, hi, lo);
        collect(0, hi, lo);
        check("dt2_hi", 64'(hi), 64'h00C);
        check("dt2_lo", 64'(lo), 64'h3C0);

        // Enable drop at cnt 1 with duty 5
        write(0, 32'd5);
        wait_cnt(0);
        tick();
        enable = 1'b0;
        tick();
        check("dis_out", 64'(pwm_out), 64'h0);
        check("dis_out_n", 64'(pwm_out_n), 64'h0);
        tick();
        check("dis_hold", 64'({pwm_out, pwm_out_n}), 64'h0);
        enable = 1'b1;

        // Dead time 0 switches directly
        deadtime_cycles = 8'd0;
        write(0, 32'd4);
        wait_cnt(0);
        collect(0, hi, lo);
        collect(0, hi, lo);
        check("dt0_hi", 64'(hi), 64'h00F);
        check("dt0_lo", 64'(lo), 64'h3F0);
`endif

        check("no_overlap", 64'(overlap), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
